// File: rtl/pc_next_unit.sv
// Program counter and next-PC generator for a single-cycle MIPS datapath.
// It produces the fetch address for the 4 KB instruction memory, picks the
// next PC (sequential, branch, jump or register jump) and checks that the
// target is aligned and inside the fetch window. It also counts retired
// PC updates and halts on the first illegal target until reset.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [15:0] immediate16,
  input  logic [25:0] immediate26,
  input  logic [31:0] rs_data,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic [1:0]  err_code,
  output logic [31:0] retired
);

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  localparam logic [1:0] OP_SEQ    = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_JUMP   = 2'b10;
  localparam logic [1:0] OP_JR     = 2'b11;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_RANGE = 2'b01;
  localparam logic [1:0] ERR_ALIGN = 2'b10;

  // Last legal fetch address: the final word of the instruction memory.
  localparam logic [31:0] LAST_PC = RESET_PC + 32'(IM_BYTES) - 32'd4;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] retired_q, retired_d;
  logic [1:0]  err_q, err_d;

  logic [31:0] br_offset;
  logic [31:0] tgt;
  logic        misaligned;
  logic        out_of_range;

  // Sequential address and the sign-extended, word-scaled branch offset.
  assign pc_plus4  = pc_q + 32'd4;
  assign br_offset = {{14{immediate16[15]}}, immediate16, 2'b00};

  // Select the next-PC candidate from the decoded operation.
  always_comb begin
    // NOTE: every path assigns tgt, with a default first, so no latch is inferred.
    tgt = pc_plus4;
    unique case (npc_op)
      OP_SEQ:    tgt = pc_plus4;
      OP_BRANCH: tgt = br_taken ? (pc_plus4 + br_offset) : pc_plus4;
      OP_JUMP:   tgt = {pc_plus4[31:28], immediate26, 2'b00};
      OP_JR:     tgt = rs_data;
      default:   tgt = pc_plus4;
    endcase
  end

  // Legality of the candidate; misalignment takes precedence over range.
  assign misaligned   = (tgt[1:0] != 2'b00);
  assign out_of_range = (tgt < RESET_PC) || (tgt > LAST_PC);

  // Next-state and next-register values for the RUN/HALT machine.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    retired_d = retired_q;
    err_d     = err_q;
    unique case (state_q)
      RUN: begin
        if (!stall) begin
          if (misaligned) begin
            state_d = HALT;
            err_d   = ERR_ALIGN;
          end else if (out_of_range) begin
            state_d = HALT;
            err_d   = ERR_RANGE;
          end else begin
            pc_d      = tgt;
            retired_d = retired_q + 32'd1;
          end
        end
      end
      HALT: begin
        // Frozen until reset.
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and architectural registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values computed before the edge.
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      retired_q <= 32'd0;
      err_q     <= ERR_NONE;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      retired_q <= retired_d;
      err_q     <= err_d;
    end
  end

  assign pc       = pc_q;
  assign retired  = retired_q;
  assign err_code = err_q;
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed testbench for pc_next_unit: drives hand-built vectors one clock
// edge at a time and compares outputs to hand-computed values.
module tb_pc_next_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [15:0] immediate16;
  logic [25:0] immediate26;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic [1:0]  err_code;
  logic [31:0] retired;

  int n_checks = 0;
  int n_pass   = 0;

  pc_next_unit #(
    .RESET_PC(32'h0000_0000),
    .IM_BYTES(4096)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .npc_op(npc_op),
    .br_taken(br_taken),
    .immediate16(immediate16),
    .immediate26(immediate26),
    .rs_data(rs_data),
    .pc(pc),
    .pc_plus4(pc_plus4),
    .halted(halted),
    .err_code(err_code),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
  endtask

  // Present one set of inputs and advance one rising edge; outputs are
  // sampled 1 ns after the edge.
  task automatic cyc(input logic rn, input logic st, input logic [1:0] op,
                     input logic bt, input logic [15:0] i16,
                     input logic [25:0] i26, input logic [31:0] rs);
    rst_n       = rn;
    stall       = st;
    npc_op      = op;
    br_taken    = bt;
    immediate16 = i16;
    immediate26 = i26;
    rs_data     = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic seq();                  cyc(1'b1, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0); endtask
  task automatic jr(input logic [31:0] a); cyc(1'b1, 1'b0, 2'b11, 1'b0, 16'h0, 26'h0, a); endtask
  task automatic reset_edge();           cyc(1'b0, 1'b0, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0); endtask

  task automatic check_state(input string tag, input logic [31:0] e_pc,
                             input logic e_halt, input logic [1:0] e_err,
                             input logic [31:0] e_ret);
    check({tag, ".pc"}, pc, e_pc);
    check({tag, ".halted"}, 32'(halted), 32'(e_halt));
    check({tag, ".err"}, 32'(err_code), 32'(e_err));
    check({tag, ".retired"}, retired, e_ret);
  endtask

  initial begin
    // Reset held for two edges.
    reset_edge();
    reset_edge();
    check_state("reset", 32'h0, 1'b0, 2'b00, 32'd0);
    check("reset.pc_plus4", pc_plus4, 32'h4);

    // Five sequential fetches.
    seq(); check("seq1.pc", pc, 32'd4);
    seq(); check("seq2.pc", pc, 32'd8);
    seq(); check("seq3.pc", pc, 32'd12);
    seq(); check("seq4.pc", pc, 32'd16);
    seq(); check("seq5.pc", pc, 32'd20);
    check("seq5.retired", retired, 32'd5);
    check("seq5.pc_plus4", pc_plus4, 32'd24);

    // Branches from pc=0x10.
    jr(32'h10); check("jr10.pc", pc, 32'h10);
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 16'hFFFE, 26'h0, 32'h0);
    check_state("br_back", 32'h0C, 1'b0, 2'b00, 32'd7);
    jr(32'h10);
    cyc(1'b1, 1'b0, 2'b01, 1'b0, 16'hFFFE, 26'h0, 32'h0);
    check_state("br_not_taken", 32'h14, 1'b0, 2'b00, 32'd9);
    jr(32'h10);
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 16'hFFFF, 26'h0, 32'h0);
    check_state("br_self1", 32'h10, 1'b0, 2'b00, 32'd11);
    cyc(1'b1, 1'b0, 2'b01, 1'b1, 16'hFFFF, 26'h0, 32'h0);
    check_state("br_self2", 32'h10, 1'b0, 2'b00, 32'd12);

    // Jump and register jump.
    jr(32'h20); check("jr20.pc", pc, 32'h20);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 16'h0, 26'h000_0040, 32'h0);
    check_state("jump", 32'h100, 1'b0, 2'b00, 32'd14);
    jr(32'h84);
    check_state("jr84", 32'h84, 1'b0, 2'b00, 32'd15);
    jr(32'h86);
    check_state("jr_misalign", 32'h84, 1'b1, 2'b10, 32'd15);

    // Frozen in HALT.
    repeat (4) seq();
    check_state("halt_frozen", 32'h84, 1'b1, 2'b10, 32'd15);
    cyc(1'b1, 1'b1, 2'b10, 1'b0, 16'h0, 26'h40, 32'h0);
    check_state("halt_stall", 32'h84, 1'b1, 2'b10, 32'd15);

    // Reset with stall asserted clears everything; fetch resumes.
    cyc(1'b0, 1'b1, 2'b00, 1'b0, 16'h0, 26'h0, 32'h0);
    check_state("rst_stall", 32'h0, 1'b0, 2'b00, 32'd0);
    seq();
    check_state("resume", 32'h4, 1'b0, 2'b00, 32'd1);

    // Sequential fetch past the last word.
    jr(32'hFFC);
    check_state("jr_last", 32'hFFC, 1'b0, 2'b00, 32'd2);
    check("last.pc_plus4", pc_plus4, 32'h1000);
    seq();
    check_state("seq_oob", 32'hFFC, 1'b1, 2'b01, 32'd2);

    // Jump to 0x1000 is out of range.
    reset_edge();
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 16'h0, 26'h400, 32'h0);
    check_state("jump_oob", 32'h0, 1'b1, 2'b01, 32'd0);

    // Misaligned and out of range together: alignment wins.
    reset_edge();
    jr(32'h2002);
    check_state("both_bad", 32'h0, 1'b1, 2'b10, 32'd0);

    // Stall holds a pending jump for three edges.
    reset_edge();
    repeat (3) cyc(1'b1, 1'b1, 2'b10, 1'b0, 16'h0, 26'h40, 32'h0);
    check_state("stall3", 32'h0, 1'b0, 2'b00, 32'd0);
    cyc(1'b1, 1'b0, 2'b10, 1'b0, 16'h0, 26'h40, 32'h0);
    check_state("unstall", 32'h100, 1'b0, 2'b00, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
